// File: rtl/line_assembler.sv
// Packs the PPU's serial 2-bit pixel stream, palette-mapped through BGP, into four bitplanes and commits each finished line atomically.
// Optional build macro LINE_ASM_OVERRUN_CNT_EN adds the saturating overrunCount output.
module line_assembler #(
   parameter int LINE_PIXELS = 160,
   parameter int LINE_COUNT  = 144
) (
   input  logic                   pixelClk,
   input  logic                   reset,
   input  logic                   frameStart,
   input  logic                   pixValid,
   output logic                   pixReady,
   input  logic [1:0]             pixColor,
   input  logic [7:0]             BGP,
   output logic [LINE_PIXELS-1:0] LineBuffer0,
   output logic [LINE_PIXELS-1:0] LineBuffer1,
   output logic [LINE_PIXELS-1:0] LineBuffer2,
   output logic [LINE_PIXELS-1:0] LineBuffer3,
   output logic [7:0]             LY,
   output logic                   lineDone,
`ifdef LINE_ASM_OVERRUN_CNT_EN
   output logic [7:0]             overrunCount,
`endif
   output logic [1:0]             state_dbg
);

   localparam int COL_W = $clog2(LINE_PIXELS);

   localparam logic [1:0] ST_WAIT_FRAME = 2'd0;
   localparam logic [1:0] ST_FILL       = 2'd1;
   localparam logic [1:0] ST_COMMIT     = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [COL_W-1:0]       col_q, col_d;
   logic [7:0]             line_q, line_d;
   logic [LINE_PIXELS-1:0] work0_q, work0_d, work1_q, work1_d;
   logic [LINE_PIXELS-1:0] work2_q, work2_d, work3_q, work3_d;
   logic [LINE_PIXELS-1:0] lb0_q, lb0_d, lb1_q, lb1_d, lb2_q, lb2_d, lb3_q, lb3_d;
   logic [7:0]             ly_q, ly_d;
   logic                   done_q, done_d;
   logic [1:0]             shade;
   logic [3:0]             intensity;
   logic                   accept;

   // Handshake: a pixel transfers in a cycle where pixValid && pixReady; pixReady
   // depends only on state, and a pixel offered while pixReady=0 is simply dropped.
   assign pixReady  = (state_q == ST_FILL);
   assign accept    = pixValid && pixReady;
   assign state_dbg = state_q;

   always_comb begin
      shade = BGP[1:0];
      case (pixColor)
         2'd0:    shade = BGP[1:0];
         2'd1:    shade = BGP[3:2];
         2'd2:    shade = BGP[5:4];
         default: shade = BGP[7:6];
      endcase
      intensity = ~{shade, shade};
   end

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      line_d  = line_q;
      work0_d = work0_q;
      work1_d = work1_q;
      work2_d = work2_q;
      work3_d = work3_q;
      lb0_d   = lb0_q;
      lb1_d   = lb1_q;
      lb2_d   = lb2_q;
      lb3_d   = lb3_q;
      ly_d    = ly_q;
      done_d  = 1'b0;
      // A frame start abandons any partial line and suppresses a pending commit;
      // stale working bits are harmless since every column is rewritten first.
      if (frameStart) begin
         state_d = ST_FILL;
         col_d   = '0;
         line_d  = '0;
      end else begin
         case (state_q)
            ST_WAIT_FRAME: state_d = ST_WAIT_FRAME;
            ST_FILL: begin
               if (accept) begin
                  work0_d[col_q] = intensity[3];
                  work1_d[col_q] = intensity[2];
                  work2_d[col_q] = intensity[1];
                  work3_d[col_q] = intensity[0];
                  col_d          = col_q + COL_W'(1);
                  if (col_q == COL_W'(LINE_PIXELS - 1)) begin
                     state_d = ST_COMMIT;
                  end
               end
            end
            ST_COMMIT: begin
               lb0_d  = work0_q;
               lb1_d  = work1_q;
               lb2_d  = work2_q;
               lb3_d  = work3_q;
               ly_d   = line_q;
               done_d = 1'b1;
               line_d = line_q + 8'd1;
               col_d  = '0;
               state_d = (line_q == 8'(LINE_COUNT - 1)) ? ST_WAIT_FRAME : ST_FILL;
            end
            default: state_d = ST_WAIT_FRAME;
         endcase
      end
   end

   always_ff @(posedge pixelClk) begin
      if (reset) begin
         state_q <= ST_WAIT_FRAME;
         col_q   <= '0;
         line_q  <= '0;
         work0_q <= '0;
         work1_q <= '0;
         work2_q <= '0;
         work3_q <= '0;
         lb0_q   <= '0;
         lb1_q   <= '0;
         lb2_q   <= '0;
         lb3_q   <= '0;
         ly_q    <= 8'd255;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         line_q  <= line_d;
         work0_q <= work0_d;
         work1_q <= work1_d;
         work2_q <= work2_d;
         work3_q <= work3_d;
         lb0_q   <= lb0_d;
         lb1_q   <= lb1_d;
         lb2_q   <= lb2_d;
         lb3_q   <= lb3_d;
         ly_q    <= ly_d;
         done_q  <= done_d;
      end
   end

   assign LineBuffer0 = lb0_q;
   assign LineBuffer1 = lb1_q;
   assign LineBuffer2 = lb2_q;
   assign LineBuffer3 = lb3_q;
   assign LY          = ly_q;
   assign lineDone    = done_q;

`ifdef LINE_ASM_OVERRUN_CNT_EN
   logic [7:0] ovr_q, ovr_d;

   always_comb begin
      ovr_d = ovr_q;
      if (frameStart) begin
         ovr_d = 8'd0;
      end else if (pixValid && !pixReady && (ovr_q != 8'hFF)) begin
         ovr_d = ovr_q + 8'd1;
      end
   end

   always_ff @(posedge pixelClk) begin
      if (reset) begin
         ovr_q <= 8'd0;
      end else begin
         ovr_q <= ovr_d;
      end
   end

   assign overrunCount = ovr_q;
`endif

endmodule

// File: tb/tb_line_assembler.sv
// Directed bench for line_assembler: spec-level pixel/line model checked every cycle, plus literal expectations.
`timescale 1ns/1ps
module tb_line_assembler;
   localparam int LP = 160;
   localparam int LC = 144;

   logic          clk = 1'b0;
   logic          reset, frame_start, pix_valid;
   logic [1:0]    pix_color;
   logic [7:0]    bgp;
   logic          pix_ready, line_done;
   logic [LP-1:0] lb0, lb1, lb2, lb3;
   logic [7:0]    ly;
   logic [1:0]    state_dbg;
`ifdef LINE_ASM_OVERRUN_CNT_EN
   logic [7:0]    overrun_count;
`endif

   line_assembler dut (
      .pixelClk(clk), .reset(reset), .frameStart(frame_start),
      .pixValid(pix_valid), .pixReady(pix_ready), .pixColor(pix_color), .BGP(bgp),
      .LineBuffer0(lb0), .LineBuffer1(lb1), .LineBuffer2(lb2), .LineBuffer3(lb3),
      .LY(ly), .lineDone(line_done),
`ifdef LINE_ASM_OVERRUN_CNT_EN
      .overrunCount(overrun_count),
`endif
      .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;
   logic [7:0] ly_seen[$];

   task automatic check(input string name, input logic [LP-1:0] got, input logic [LP-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // behavioural model: pixels land in an array by column, lines publish as whole vectors
   logic [3:0]    m_work[LP];
   logic [LP-1:0] m_lb[4];
   logic [7:0]    m_ly;
   int            m_col, m_line, m_ovr;
   bit            m_in_frame, m_gap, m_done, m_ready;

   function automatic logic [3:0] to_intensity(input logic [7:0] pal, input logic [1:0] c);
      logic [7:0] p;
      int sh;
      logic [3:0] lut[4];
      lut[0] = 4'hF; lut[1] = 4'hA; lut[2] = 4'h5; lut[3] = 4'h0;
      p  = pal >> (2 * int'(c));
      sh = int'(p[1:0]);
      return lut[sh];
   endfunction

   task automatic model_step();
      if (reset) begin
         for (int x = 0; x < LP; x++) m_work[x] = 4'h0;
         for (int k = 0; k < 4; k++) m_lb[k] = '0;
         m_ly = 8'd255; m_col = 0; m_line = 0; m_ovr = 0;
         m_in_frame = 0; m_gap = 0; m_done = 0; m_ready = 0;
      end else begin
         m_done = 0;
         if (frame_start) m_ovr = 0;
         else if (pix_valid && !m_ready && m_ovr < 255) m_ovr++;
         if (frame_start) begin
            m_in_frame = 1; m_col = 0; m_line = 0; m_gap = 0;
         end else if (m_gap) begin
            for (int x = 0; x < LP; x++) begin
               m_lb[0][x] = m_work[x][3];
               m_lb[1][x] = m_work[x][2];
               m_lb[2][x] = m_work[x][1];
               m_lb[3][x] = m_work[x][0];
            end
            m_ly = 8'(m_line); m_done = 1; m_gap = 0; m_line++;
            if (m_line == LC) m_in_frame = 0;
         end else if (m_ready && pix_valid) begin
            m_work[m_col] = to_intensity(bgp, pix_color);
            m_col++;
            if (m_col == LP) begin m_col = 0; m_gap = 1; end
         end
         m_ready = m_in_frame && !m_gap;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // per-cycle compare against the model
   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         check("pixReady", LP'(pix_ready), LP'(m_ready));
         check("lineDone", LP'(line_done), LP'(m_done));
         check("LY", LP'(ly), LP'(m_ly));
         check("LineBuffer0", lb0, m_lb[0]);
         check("LineBuffer1", lb1, m_lb[1]);
         check("LineBuffer2", lb2, m_lb[2]);
         check("LineBuffer3", lb3, m_lb[3]);
`ifdef LINE_ASM_OVERRUN_CNT_EN
         check("overrunCount", LP'(overrun_count), LP'(m_ovr));
`endif
         if (line_done === 1'b1) ly_seen.push_back(ly);
      end
   end

   // drivers: every task starts and ends just after a falling edge
   task automatic idle(input int n);
      pix_valid = 1'b0; frame_start = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_frame();
      pix_valid = 1'b0; frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic send_pixel(input logic [1:0] c);
      int n;
      bit acc;
      n = 0; acc = 0;
      pix_valid = 1'b1; pix_color = c;
      while (!acc) begin
         acc = pix_ready;
         @(negedge clk);
         n++;
         if (!acc && n > 1000) begin
            checks++; errors++;
            $display("FAIL send_pixel: no pixReady within %0d cycles", n);
            break;
         end
      end
      pix_valid = 1'b0;
   endtask

   task automatic send_pixels(input int mode, input int count, input int gapmax);
      logic [1:0] c;
      logic [7:0] xb;
      for (int x = 0; x < count; x++) begin
         xb = 8'(x);
         if (mode == 0) c = 2'd0;
         else if (mode == 1) c = xb[1:0];
         else c = 2'($urandom_range(0, 3));
         send_pixel(c);
         if (gapmax > 0) idle($urandom_range(0, gapmax));
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_color = 2'd0; bgp = 8'hE4;
      @(negedge clk);
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset LY", LP'(ly), LP'(8'd255));
      check("reset LB0", lb0, '0);

      // no frameStart: pixels must all be refused
      pix_valid = 1'b1;
      repeat (500) @(negedge clk);
      pix_valid = 1'b0;
      check("idle pixReady", LP'(pix_ready), LP'(1'b0));
      check("idle LY", LP'(ly), LP'(8'd255));
      check("idle LB3", lb3, '0);

      // line 0: all colour 0 -> white
      ly_seen.delete();
      pulse_frame();
      bgp = 8'hE4;
      send_pixels(0, LP, 0);
      check("white not yet done", LP'(line_done), LP'(1'b0));
      idle(1);
      check("white lineDone", LP'(line_done), LP'(1'b1));
      check("white LY", LP'(ly), LP'(8'd0));
      check("white LB0", lb0, {LP{1'b1}});
      check("white LB3", lb3, {LP{1'b1}});

      // line 1: colour = column[1:0]
      send_pixels(1, LP, 0);
      idle(1);
      check("ramp LY", LP'(ly), LP'(8'd1));
      check("ramp LB0", LP'(lb0[7:0]), LP'(8'b0011_0011));
      check("ramp LB1", LP'(lb1[7:0]), LP'(8'b0101_0101));
      check("ramp LB2", LP'(lb2[7:0]), LP'(8'b0011_0011));
      check("ramp LB3", LP'(lb3[7:0]), LP'(8'b0101_0101));

      // rest of the frame with random palettes and idle gaps
      for (int l = 2; l < LC; l++) begin
         bgp = 8'($urandom_range(0, 255));
         send_pixels(2, LP, 1);
      end
      idle(4);
      check("frame line count", LP'(ly_seen.size()), LP'(LC));
      for (int i = 0; i < ly_seen.size() && i < LC; i++)
         check("frame LY step", LP'(ly_seen[i]), LP'(i));
      check("frame end LY", LP'(ly), LP'(8'd143));
      pix_valid = 1'b1;
      repeat (20) @(negedge clk);
      pix_valid = 1'b0;
      check("frame end pixReady", LP'(pix_ready), LP'(1'b0));

      // abort line 5 halfway
      pulse_frame();
      for (int l = 0; l < 5; l++) send_pixels(2, LP, 1);
      send_pixels(2, 80, 0);
      idle(2);
      pulse_frame();
      idle(3);
      check("abort LY held", LP'(ly), LP'(8'd4));
      bgp = 8'hE4;
      send_pixels(1, LP - 1, 0);
      check("abort LY before commit", LP'(ly), LP'(8'd4));
      send_pixels(0, 1, 0);
      idle(1);
      check("abort recommit LY", LP'(ly), LP'(8'd0));
      check("abort recommit lineDone", LP'(line_done), LP'(1'b1));
      check("abort recommit LB0", LP'(lb0[7:0]), LP'(8'b0011_0011));

      // reset mid-line
      send_pixels(2, 50, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset LY", LP'(ly), LP'(8'd255));
      check("midreset LB1", lb1, '0);
      check("midreset pixReady", LP'(pix_ready), LP'(1'b0));

`ifdef LINE_ASM_OVERRUN_CNT_EN
      pulse_frame();
      for (int l = 0; l < 4; l++) send_pixels(2, LP, 0);
      idle(2);
      check("overrun three commits", LP'(overrun_count), LP'(8'd3));
      pulse_frame();
      check("overrun cleared", LP'(overrun_count), LP'(8'd0));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      pix_valid = 1'b1;
      repeat (300) @(negedge clk);
      pix_valid = 1'b0;
      check("overrun saturate", LP'(overrun_count), LP'(8'd255));
`endif

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/line_assembler.md
Name: line_assembler

Overview:
- Upstream stage of the VGA scan-out block.
- Accepts the PPU's serial stream of 2-bit Game Boy colour indices.
- Maps each index through the BGP palette to a 4-bit intensity and packs 160 pixels into four working bitplanes.
- On line completion, commits the bitplanes atomically to the LineBuffer0..3 outputs and advances LY, which the scan-out block uses as its line-RAM write trigger.

Parameters:
- LINE_PIXELS, 160, pixels per line; also the bitplane width.
- LINE_COUNT, 144, visible lines per frame.

Ports:
- pixelClk, input, 1, single clock; all state on the rising edge.
- reset, input, 1, synchronous, active-high.
- frameStart, input, 1, one-cycle pulse at the start of each frame (LY=0 line begins).
- pixValid, input, 1, a pixel is offered this cycle.
- pixReady, output, 1, block accepts a pixel this cycle; a transfer happens when pixValid && pixReady.
- pixColor, input, 2, colour index 0..3 of the offered pixel.
- BGP, input, 8, background palette; sampled on every accepted pixel.
- LineBuffer0, output, 160, intensity bit 3 of each pixel; bit x = screen column x.
- LineBuffer1, output, 160, intensity bit 2.
- LineBuffer2, output, 160, intensity bit 1.
- LineBuffer3, output, 160, intensity bit 0.
- LY, output, 8, index of the line currently presented on LineBuffer0..3.
- lineDone, output, 1, one-cycle pulse in the cycle the commit becomes visible.

Behaviour:
- Reset:
  - State WAIT_FRAME; pixReady=0; LineBuffer0..3 = 0.
  - LY = 8'd255, so the first commit of line 0 is a visible LY change. The scan-out block may write junk to its address 255 after reset; this is harmless.
  - lineDone=0; column counter = 0; line counter = 0; working planes = 0.
- Palette mapping:
  - shade = BGP[2c+1:2c] for colour index c.
  - intensity = ~{shade, shade}, giving shade 0 -> 4'hF (white), 1 -> 4'hA, 2 -> 4'h5, 3 -> 4'h0.
- Accepted pixel: write its intensity bits into working planes 0..3 at bit [column], then column++.
- State WAIT_FRAME:
  - pixReady=0.
  - frameStart -> FILL; column=0; line=0.
- State FILL:
  - pixReady=1.
  - On the accepted pixel with column==LINE_PIXELS-1 -> COMMIT.
- State COMMIT (exactly 1 cycle):
  - pixReady=0.
  - Registered update: LineBuffer0..3 <= working planes (including the final pixel, which is folded in); LY <= line; lineDone=1 in the following cycle, aligned with the new outputs.
  - line++ and column=0.
  - If line was LINE_COUNT-1 -> WAIT_FRAME; else -> FILL.
- Output timing:
  - LY and LineBuffer0..3 always change in the same cycle and are never updated separately.
  - Outputs hold stable at least LINE_PIXELS+1 cycles between commits. This satisfies the scan-out block's 2-cycle write sequence.
- Latency: last pixel accepted at cycle t -> LineBuffer/LY updated and lineDone high at t+2.
- frameStart in FILL or COMMIT (mid-frame or mid-line):
  - Discard the partial line; working planes need not be cleared because every bit is rewritten before the next commit.
  - column=0; line=0; go to FILL.
  - LineBuffer0..3 and LY keep their last committed value.
  - frameStart has priority over a simultaneous COMMIT transition, and the commit is suppressed.
- frameStart in WAIT_FRAME: normal frame start.
- pixValid while pixReady=0: pixel ignored, no state change.
- reset mid-line: immediate return to reset values, including LineBuffer0..3 = 0 and LY = 255.

Optional Feature:
- Macro: LINE_ASM_OVERRUN_CNT_EN.
- With the macro defined:
  - Extra output port overrunCount [7:0] counts cycles with pixValid && !pixReady.
  - Saturates at 255; cleared to 0 by reset and by frameStart.
  - frameStart in the same cycle as an overrun yields 0.
- Without the macro: port absent; dropped pixels are silent. All other behaviour is identical.

Test Plan:
- Reset release, no frameStart, pixValid=1 for 500 cycles -> pixReady=0 throughout; LY=255; LineBuffer0..3=0.
- frameStart, BGP=8'hE4, 160 pixels of colour 0 -> LineBuffer0..3 all ones; LY=0; lineDone 2 cycles after the last pixel.
- BGP=8'hE4, pixColor = x[1:0] for column x -> bit pattern per 4 columns: LineBuffer0=0011, LineBuffer1=0101, LineBuffer2=0011, LineBuffer3=0101 (columns 0..3, LSB first).
- Full frame, 144×160 pixels with idle gaps -> LY steps 0..143 once each; after line 143 pixReady=0 until the next frameStart; the next frame's first commit gives LY=0.
- frameStart after 80 pixels of line 5 -> LY stays 4 with its buffers unchanged; the next 160 pixels commit as LY=0.
- LINE_ASM_OVERRUN_CNT_EN defined, pixValid held high across 3 COMMIT cycles -> overrunCount=3; frameStart -> 0; 300 blocked cycles -> 255.
